// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN layer blocks: batch-norm sequencer states and
// the parameter memory address map (weight/bias interleaved per channel).
package cnn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        LOAD_B,
        WAIT_B,
        STREAM,
        DRAIN
    } bn_ctrl_state_t;

    localparam int BN_W_OFFSET     = 0;
    localparam int BN_B_OFFSET     = 1;
    localparam int BN_PARAM_STRIDE = 2;

    // Counter width that stays at least one bit when the count is 1.
    function automatic int bn_counter_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/batch_norm_ctrl_datapath.sv
// Batch_norm fixed-point datapath: y = (x * w) >> FRACTION_WIDTH + b, purely
// combinational, truncated to DATA_WIDTH with an overflow flag.
module Batch_norm #(
    parameter int DATA_WIDTH     = 32,
    parameter int FRACTION_WIDTH = 15
) (
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [DATA_WIDTH-1:0] i_weight,
    input  logic [DATA_WIDTH-1:0] i_bias,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_overflow
);

    localparam int PROD_W = 2 * DATA_WIDTH;

    logic signed [PROD_W-1:0] product;
    logic signed [PROD_W-1:0] scaled;
    logic signed [PROD_W:0]   sum;

    // The wide sum fits the narrow word when every bit above its sign bit agrees.
    function automatic logic fits_signed(input logic signed [PROD_W:0] v);
        return (v[PROD_W:DATA_WIDTH-1] == '0) || (v[PROD_W:DATA_WIDTH-1] == '1);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] truncate(input logic signed [PROD_W:0] v);
        return v[DATA_WIDTH-1:0];
    endfunction

    assign product    = PROD_W'($signed(i_data)) * PROD_W'($signed(i_weight));
    assign scaled     = product >>> FRACTION_WIDTH;
    assign sum        = {scaled[PROD_W-1], scaled} + (PROD_W+1)'($signed(i_bias));
    assign o_data     = truncate(sum);
    assign o_overflow = !fits_signed(sum);

endmodule

// File: rtl/batch_norm_ctrl.sv
// Batch-norm sequencer: per channel fetches weight/bias from parameter memory,
// then streams that channel's pixels through Batch_norm with valid/ready on both sides.
module batch_norm_ctrl
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH         = 32,
    parameter int FRACTION_WIDTH     = 15,
    parameter int NUM_CHANNELS       = 16,
    parameter int PIXELS_PER_CHANNEL = 64,
    parameter int PARAM_ADDR_WIDTH   = $clog2(2 * NUM_CHANNELS)
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_start,
    output logic                        o_busy,
    output logic                        o_done,
    output logic                        o_param_rd_en,
    output logic [PARAM_ADDR_WIDTH-1:0] o_param_addr,
    input  logic [DATA_WIDTH-1:0]       i_param_data,
    input  logic                        i_valid,
    output logic                        o_ready,
    input  logic [DATA_WIDTH-1:0]       i_data,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic [DATA_WIDTH-1:0]       o_data,
    output logic                        o_overflow
);

    localparam int CH_W  = bn_counter_width(NUM_CHANNELS);
    localparam int PIX_W = bn_counter_width(PIXELS_PER_CHANNEL);

    bn_ctrl_state_t state, state_next;

    logic [CH_W-1:0]       ch;
    logic [PIX_W-1:0]      pix;
    logic [DATA_WIDTH-1:0] weight_q;
    logic [DATA_WIDTH-1:0] bias_q;
    logic [DATA_WIDTH-1:0] bn_data;
    logic                  bn_overflow;
    logic                  in_hs;
    logic                  out_hs;
    logic                  last_pix;
    logic                  last_ch;
    logic                  done_next;

    function automatic logic [PARAM_ADDR_WIDTH-1:0] param_addr(input logic [CH_W-1:0] c,
                                                               input int offset);
        return PARAM_ADDR_WIDTH'(int'(c) * BN_PARAM_STRIDE + offset);
    endfunction

    Batch_norm #(
        .DATA_WIDTH     (DATA_WIDTH),
        .FRACTION_WIDTH (FRACTION_WIDTH)
    ) u_batch_norm (
        .i_data     (i_data),
        .i_weight   (weight_q),
        .i_bias     (bias_q),
        .o_data     (bn_data),
        .o_overflow (bn_overflow)
    );

    // A slot opens when the output register is empty or being drained this cycle.
    assign o_ready  = (state == STREAM) && (!o_valid || i_ready);
    assign in_hs    = i_valid && o_ready;
    assign out_hs   = o_valid && i_ready;
    assign last_pix = (pix == PIX_W'(PIXELS_PER_CHANNEL - 1));
    assign last_ch  = (ch == CH_W'(NUM_CHANNELS - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        o_busy        = 1'b1;
        o_param_rd_en = 1'b0;
        o_param_addr  = '0;
        done_next     = 1'b0;
        case (state)
            IDLE: begin
                o_busy = 1'b0;
                if (i_start) state_next = LOAD_W;
            end
            LOAD_W: begin
                o_param_rd_en = 1'b1;
                o_param_addr  = param_addr(ch, BN_W_OFFSET);
                state_next    = LOAD_B;
            end
            LOAD_B: begin
                o_param_rd_en = 1'b1;
                o_param_addr  = param_addr(ch, BN_B_OFFSET);
                state_next    = WAIT_B;
            end
            WAIT_B: state_next = STREAM;
            STREAM: begin
                if (in_hs && last_pix) state_next = last_ch ? DRAIN : LOAD_W;
            end
            DRAIN: begin
                if (!o_valid || i_ready) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ch         <= '0;
            pix        <= '0;
            weight_q   <= '0;
            bias_q     <= '0;
            o_data     <= '0;
            o_valid    <= 1'b0;
            o_overflow <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            o_done <= done_next;
            if (state == IDLE && i_start) begin
                ch         <= '0;
                pix        <= '0;
                o_overflow <= 1'b0;
            end
            // Read data lags the strobe by one cycle, so each capture is one state late.
            if (state == LOAD_B) weight_q <= i_param_data;
            if (state == WAIT_B) bias_q   <= i_param_data;
            if (in_hs) begin
                o_data     <= bn_data;
                o_valid    <= 1'b1;
                o_overflow <= o_overflow | bn_overflow;
                pix        <= last_pix ? '0 : pix + 1'b1;
                if (last_pix && !last_ch) ch <= ch + 1'b1;
            end else if (out_hs) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_batch_norm_ctrl.sv
// Scoreboard bench for batch_norm_ctrl (4 channels x 2 pixels, Q15 in 32 bits):
// directed pixel tables with hand-computed results, stall and control corners.
module tb_batch_norm_ctrl;

    localparam int DW   = 32;
    localparam int FW   = 15;
    localparam int NCH  = 4;
    localparam int PPC  = 2;
    localparam int AW   = 3;
    localparam int NPIX = NCH * PPC;

    logic          clk;
    logic          rst_n;
    logic          i_start;
    logic          o_busy;
    logic          o_done;
    logic          o_param_rd_en;
    logic [AW-1:0] o_param_addr;
    logic [DW-1:0] i_param_data;
    logic          i_valid;
    logic          o_ready;
    logic [DW-1:0] i_data;
    logic          o_valid;
    logic          i_ready;
    logic [DW-1:0] o_data;
    logic          o_overflow;

    batch_norm_ctrl #(
        .DATA_WIDTH         (DW),
        .FRACTION_WIDTH     (FW),
        .NUM_CHANNELS       (NCH),
        .PIXELS_PER_CHANNEL (PPC),
        .PARAM_ADDR_WIDTH   (AW)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_start       (i_start),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_param_rd_en (o_param_rd_en),
        .o_param_addr  (o_param_addr),
        .i_param_data  (i_param_data),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_data        (i_data),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_data        (o_data),
        .o_overflow    (o_overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [DW-1:0] pmem [2*NCH];
    always @(posedge clk) if (o_param_rd_en) i_param_data <= pmem[o_param_addr];

    int cyc;
    always @(posedge clk) cyc <= cyc + 1;

    int            checks;
    int            errors;
    logic [DW-1:0] exp_q [$];
    logic [AW-1:0] addr_log [$];
    int            hs_cyc [$];
    int            in_cyc [NPIX];
    int            last_hs;
    int            done_cyc;
    int            done_count;
    bit            drv_done;
    logic [DW-1:0] pix_tab [NPIX];
    logic [DW-1:0] exp_tab [NPIX];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (o_valid && i_ready) begin
                    if (exp_q.size() == 0) chk("unexpected_output", o_data, 32'hDEAD_BEEF);
                    else chk("out_data", o_data, exp_q.pop_front());
                    hs_cyc.push_back(cyc);
                    last_hs = cyc;
                end
                if (o_param_rd_en) begin
                    addr_log.push_back(o_param_addr);
                    chk("ready_low_during_load", 32'(o_ready), 32'd0);
                end
                if (o_done) begin
                    done_count++;
                    done_cyc = cyc;
                end
            end
        end
    endtask

    task automatic load_tables(input bit ovf_case);
        // weight/bias per channel: 2.0/0.5, 1.0/0.125, -1.0/0, 3.0/-0.5
        pmem[0] = ovf_case ? 32'h7FFF_0000 : 32'h0001_0000;  pmem[1] = 32'h0000_4000;
        pmem[2] = 32'h0000_8000;  pmem[3] = 32'h0000_1000;
        pmem[4] = 32'hFFFF_8000;  pmem[5] = 32'h0000_0000;
        pmem[6] = 32'h0001_8000;  pmem[7] = 32'hFFFF_C000;
        pix_tab[0] = ovf_case ? 32'h7FFF_0000 : 32'h0000_C000;
        exp_tab[0] = ovf_case ? 32'h0002_4000 : 32'h0001_C000;
        pix_tab[1] = 32'h0000_8000;
        exp_tab[1] = ovf_case ? 32'h7FFF_4000 : 32'h0001_4000;
        pix_tab[2] = 32'h0000_2000;  exp_tab[2] = 32'h0000_3000;
        pix_tab[3] = 32'hFFFF_8000;  exp_tab[3] = 32'hFFFF_9000;
        pix_tab[4] = 32'h0000_4000;  exp_tab[4] = 32'hFFFF_C000;
        pix_tab[5] = 32'h0001_0000;  exp_tab[5] = 32'hFFFF_0000;
        pix_tab[6] = 32'h0000_8000;  exp_tab[6] = 32'h0001_4000;
        pix_tab[7] = 32'h0000_4000;  exp_tab[7] = 32'h0000_8000;
    endtask

    task automatic start_pulse();
        @(posedge clk); #1;
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
    endtask

    task automatic drive();
        for (int i = 0; i < NPIX; i++) begin
            int n;
            n = 0;
            i_valid = 1'b1;
            i_data  = pix_tab[i];
            exp_q.push_back(exp_tab[i]);
            @(negedge clk);
            while (!o_ready && n < 100) begin
                n++;
                @(negedge clk);
            end
            chk("input_accepted", 32'(o_ready), 32'd1);
            in_cyc[i] = cyc;
            @(posedge clk); #1;
        end
        i_valid  = 1'b0;
        i_data   = '0;
        drv_done = 1'b1;
    endtask

    task automatic backpressure();
        logic [DW-1:0] held;
        int n;
        n = 0;
        while (hs_cyc.size() < 3 && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        i_ready = 1'b0;
        held    = o_data;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_ready_low", 32'(o_ready), 32'd0);
            chk("bp_valid_held", 32'(o_valid), 32'd1);
            if (k > 0) chk("bp_data_stable", o_data, held);
        end
        @(posedge clk); #1;
        i_ready = 1'b1;
        n = 0;
        while (!drv_done && n < 200) begin
            @(posedge clk); #2;
            n++;
        end
        i_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_no_done", 32'(o_done), 32'd0);
            chk("stall_valid_held", 32'(o_valid), 32'd1);
        end
        @(posedge clk); #1;
        i_ready = 1'b1;
    endtask

    task automatic ignore_start();
        int n;
        n = 0;
        while (hs_cyc.size() < 1 && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        n = 0;
        while (!o_ready && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        chk("stream_before_start_pulse", 32'(o_ready), 32'd1);
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        chk("busy_after_ignored_start", 32'(o_busy), 32'd1);
    endtask

    task automatic finish_run(input logic exp_ovf);
        int n;
        int base;
        base = done_count;
        n    = 0;
        while (!o_done && n < 300) begin
            @(negedge clk); #1;
            n++;
        end
        chk("done_seen", 32'(o_done), 32'd1);
        chk("done_latency", 32'(done_cyc - last_hs), 32'd1);
        chk("busy_low_at_done", 32'(o_busy), 32'd0);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        chk("overflow_at_done", 32'(o_overflow), 32'(exp_ovf));
        chk("addr_count", 32'(addr_log.size()), 32'(2 * NCH));
        for (int i = 0; i < addr_log.size() && i < 2 * NCH; i++) chk("param_addr", 32'(addr_log[i]), 32'(i));
        @(negedge clk); #1;
        chk("done_single_pulse", 32'(o_done), 32'd0);
        chk("done_count", 32'(done_count - base), 32'd1);
        chk("overflow_sticky", 32'(o_overflow), 32'(exp_ovf));
    endtask

    task automatic run_map(input bit timing, input bit stress, input logic exp_ovf);
        hs_cyc.delete();
        addr_log.delete();
        drv_done = 1'b0;
        start_pulse();
        if (stress) chk("start_clears_overflow", 32'(o_overflow), 32'd0);
        if (timing) begin
            chk("busy_in_load_w", 32'(o_busy), 32'd1);
            chk("rd_en_in_load_w", 32'(o_param_rd_en), 32'd1);
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                chk("ready_low_after_start", 32'(o_ready), 32'd0);
            end
            @(negedge clk);
            chk("first_ready_cycle4", 32'(o_ready), 32'd1);
            @(posedge clk); #1;
        end
        fork
            drive();
            begin if (stress) backpressure(); end
            begin if (stress) ignore_start(); end
        join
        finish_run(exp_ovf);
        if (timing) begin
            for (int i = 0; i < NPIX; i++) chk("pixel_latency", 32'(hs_cyc[i] - in_cyc[i]), 32'd1);
            for (int c = 0; c < NCH; c++) chk("full_rate", 32'(in_cyc[2*c+1] - in_cyc[2*c]), 32'd1);
            for (int c = 1; c < NCH; c++) chk("channel_switch", 32'(in_cyc[2*c] - in_cyc[2*c-1]), 32'd4);
        end
    endtask

    initial begin
        int dones_before;
        checks     = 0;
        errors     = 0;
        done_count = 0;
        last_hs    = 0;
        done_cyc   = 0;
        rst_n      = 1'b0;
        i_start    = 1'b0;
        i_valid    = 1'b0;
        i_data     = '0;
        i_ready    = 1'b1;
        drv_done   = 1'b0;
        fork
            monitor();
            begin
                #200000;
                $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
                $fatal(1);
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_rd_en", 32'(o_param_rd_en), 32'd0);
        chk("rst_addr", 32'(o_param_addr), 32'd0);
        chk("rst_ready", 32'(o_ready), 32'd0);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_data", o_data, 32'd0);
        chk("rst_overflow", 32'(o_overflow), 32'd0);
        rst_n = 1'b1;

        load_tables(1'b0);
        run_map(1'b1, 1'b0, 1'b0);
        load_tables(1'b1);
        run_map(1'b0, 1'b0, 1'b1);
        load_tables(1'b0);
        run_map(1'b0, 1'b1, 1'b0);

        // Abort in LOAD_B: everything returns to reset values and no done follows.
        dones_before = done_count;
        start_pulse();
        @(posedge clk); #1;
        chk("abort_in_load_b_addr", 32'(o_param_addr), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(o_busy), 32'd0);
        chk("abort_done", 32'(o_done), 32'd0);
        chk("abort_rd_en", 32'(o_param_rd_en), 32'd0);
        chk("abort_addr", 32'(o_param_addr), 32'd0);
        chk("abort_ready", 32'(o_ready), 32'd0);
        chk("abort_valid", 32'(o_valid), 32'd0);
        chk("abort_data", o_data, 32'd0);
        chk("abort_overflow", 32'(o_overflow), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        chk("abort_no_done", 32'(done_count - dones_before), 32'd0);
        chk("abort_idle", 32'(o_busy), 32'd0);

        run_map(1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/batch_norm_ctrl.md
# batch_norm_ctrl

Sequencer for the Batch_norm fixed-point datapath. On `i_start` it walks every channel of one feature map. Per channel, it fetches that channel's weight and bias from a parameter memory, then streams the channel's pixels through the datapath with valid/ready handshakes on both sides. It sits between the convolution output stream and the next layer's input stream, and reports a sticky overflow flag and a done pulse per feature map.

## Interface
Parameters:
- `DATA_WIDTH`, 32, fixed-point word width.
- `FRACTION_WIDTH`, 15, fractional bits (Q format).
- `NUM_CHANNELS`, 16, channels per feature map (≥1).
- `PIXELS_PER_CHANNEL`, 64, pixels per channel (≥1).
- `PARAM_ADDR_WIDTH`, `$clog2(2*NUM_CHANNELS)`, parameter memory address width.

Ports:
- `i_clk` in 1: clock. One clock domain.
- `i_rst_n` in 1: reset. Asynchronous, active-low.
- `i_start` in 1: start one feature map. Accepted only in IDLE.
- `o_busy` in→out 1: high in every state except IDLE.
- `o_done` out 1: one-cycle pulse after the final output handshake.
- `o_param_rd_en` out 1: parameter memory read strobe.
- `o_param_addr` out `PARAM_ADDR_WIDTH`: weight of channel c at address 2c; bias at 2c+1.
- `i_param_data` in `DATA_WIDTH`: read data, valid exactly 1 cycle after `o_param_rd_en`.
- `i_valid` in 1, `o_ready` out 1, `i_data` in `DATA_WIDTH`: input pixel stream.
- `o_valid` out 1, `i_ready` in 1, `o_data` out `DATA_WIDTH`: output pixel stream.
- `o_overflow` out 1: sticky. Set when any accepted pixel overflows. Cleared on accepted `i_start`.

## Operation
- FSM states: IDLE, LOAD_W, LOAD_B, WAIT_B, STREAM, DRAIN.
- IDLE: on `i_start`, go to LOAD_W. Clear the channel counter, pixel counter and `o_overflow`.
- LOAD_W: assert `rd_en` with `addr=2*ch`. Next state LOAD_B.
- LOAD_B: assert `rd_en` with `addr=2*ch+1`. Capture `i_param_data` into `weight_q`. Next state WAIT_B.
- WAIT_B: capture `i_param_data` into `bias_q`. Next state STREAM.
- STREAM: `o_ready = !o_valid || i_ready`. An input handshake (`i_valid && o_ready`) does three things:
  - registers the Batch_norm result (from `i_data`, `weight_q`, `bias_q`) into `o_data` and sets `o_valid`;
  - ORs the datapath overflow into `o_overflow`;
  - increments the pixel counter.
- Last pixel of a channel (`pix==PIXELS_PER_CHANNEL-1`): the pixel counter wraps to 0.
  - If `ch==NUM_CHANNELS-1`, go to DRAIN.
  - Otherwise increment `ch` and go to LOAD_W.
- `o_ready` is 0 outside STREAM.
- Output handshake (`o_valid && i_ready`) clears `o_valid` unless a new pixel loads in the same cycle. Simultaneous accept and emit keeps `o_valid` high with the new data.
- A pending output survives LOAD_W/LOAD_B/WAIT_B unchanged. It may be consumed in those states.
- DRAIN: wait for `!o_valid`, or for an output handshake this cycle. Then pulse `o_done` and go to IDLE.
- `i_start` outside IDLE is ignored.
- Arithmetic: datapath result is truncated to `DATA_WIDTH`, Q(`FRACTION_WIDTH`). The controller does no arithmetic besides its counters.

## Timing
- Reset values: state IDLE. `o_busy`, `o_done`, `o_param_rd_en`, `o_ready` and `o_valid` are 0. `o_param_addr`, `o_data`, `o_overflow`, counters, `weight_q` and `bias_q` are 0.
- Reset mid-operation aborts immediately. No `o_done` is produced and the pending output is discarded.
- `i_start` at cycle 0 gives LOAD_W at 1, LOAD_B at 2, WAIT_B at 3, and first `o_ready` at cycle 4.
- Channel switch overhead: 3 cycles with `o_ready=0`.
- Pixel latency: input handshake at cycle n gives `o_valid` at n+1.
- Full throughput is 1 pixel per cycle within a channel while `i_ready=1`.
- `o_done` occurs 1 cycle after the final output handshake, concurrent with `o_busy` falling. `o_busy` falls with the DRAIN→IDLE transition.
- A new `i_start` is accepted the cycle after `o_done`.

## Structure
- Shared package `cnn_pkg` holds:
  - the FSM state enum `bn_ctrl_state_t`;
  - the parameter address map constants (`BN_W_OFFSET=0`, `BN_B_OFFSET=1`, stride 2).
- Single sub-module: the existing `Batch_norm` datapath, instantiated combinationally. Its inputs are `i_data`, `weight_q` and `bias_q`; its outputs feed the output register and the overflow OR.

## Test plan
- Basic compute, Q15 (`NUM_CHANNELS=1`, `PIXELS_PER_CHANNEL=1`): weight 0x10000 (2.0), bias 0x4000 (0.5), pixel 0xC000 (1.5) → `o_data=0x1C000`, `o_overflow=0`, `o_done` 1 cycle after the output handshake.
- Address sequence (`NUM_CHANNELS=4`, `PIXELS_PER_CHANNEL=2`): `o_param_addr` reads 0,1,2,3,…,7, each pair preceded by 3 cycles of `o_ready=0`. Every output uses its own channel's weight/bias.
- Backpressure: hold `i_ready=0` for 5 cycles mid-stream → `o_data` stable, `o_ready=0` and no input loss. Full-rate streaming with `i_valid=i_ready=1` → 1 output per cycle within each channel.
- Overflow: weight 0x7FFF0000 with pixel 0x7FFF0000 → `o_overflow=1` and it stays set through `o_done`. The next `i_start` clears it.
- Control corners:
  - `i_start` pulsed during STREAM → ignored;
  - `i_rst_n` low during LOAD_B → all outputs reset to 0, no `o_done`;
  - final channel's output stalled 3 cycles → `o_done` waits until the handshake.
